// File: rtl/zero_indices_feeder.sv
// Buffers producer vectors in a small FIFO and launches them one at a time into the
// zero-index enumeration engine. Optional all-ones skipping: ZERO_INDICES_FEEDER_SKIP_ONES_EN.
module zero_indices_feeder #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic [W-1:0]           s_vector,
    output logic                   s_ready,
    input  logic                   eng_busy,
    output logic                   eng_start,
    output logic [W-1:0]           eng_vector,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            dropped_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] head;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;
    logic         launch;
    logic         skip;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready = !full && !rst;
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr[AW-1:0]];

`ifdef ZERO_INDICES_FEEDER_SKIP_ONES_EN
    assign skip = !empty && (head == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_cnt <= '0;
        end else if (skip && (dropped_cnt != 16'hFFFF)) begin
            dropped_cnt <= dropped_cnt + 16'd1;
        end
    end
`else
    assign skip        = 1'b0;
    assign dropped_cnt = '0;
`endif

    // Busy is registered inside the engine and lags start by a cycle, so the
    // pulse we are currently driving must also block a new launch.
    assign launch = !empty && !eng_busy && !eng_start && !skip;
    assign pop    = launch || skip;

    // NOTE: storage has no reset; entries are only ever read between the pointers,
    // which are reset, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_vector;
        end
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            eng_start  <= 1'b0;
            eng_vector <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
            eng_start <= launch;
            if (launch) begin
                eng_vector <= head;
            end
        end
    end

endmodule

// File: tb/tb_zero_indices_feeder.sv
// Scoreboard bench for zero_indices_feeder: directed and random producer traffic,
// a queue-based reference model and a small engine model driving eng_busy.
module tb_zero_indices_feeder;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;
`ifdef ZERO_INDICES_FEEDER_SKIP_ONES_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum int {BUSY_MODEL, BUSY_HIGH, BUSY_LOW} busy_mode_e;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [W-1:0]  s_vector;
    logic          s_ready;
    logic          eng_busy = 1'b0;
    logic          eng_start;
    logic [W-1:0]  eng_vector;
    logic [OW-1:0] occupancy;
    logic [15:0]   dropped_cnt;

    busy_mode_e   busy_mode   = BUSY_MODEL;
    int           n_checks    = 0;
    int           n_fail      = 0;
    int           n_launch    = 0;
    int           exp_dropped = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_vec    = '0;

    always #5 clk = ~clk;

    zero_indices_feeder #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_vector    (s_vector),
        .s_ready     (s_ready),
        .eng_busy    (eng_busy),
        .eng_start   (eng_start),
        .eng_vector  (eng_vector),
        .occupancy   (occupancy),
        .dropped_cnt (dropped_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Engine model: busy is high for the three cycles following each start pulse.
    int   busy_rem   = 0;
    logic prev_start = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            busy_rem = 0;
        end else if (prev_start) begin
            busy_rem = 3;
        end
        eng_busy = (busy_mode == BUSY_HIGH) || ((busy_mode == BUSY_MODEL) && (busy_rem > 0));
        if (busy_rem > 0) busy_rem--;
        prev_start = eng_start;
    end

    // Monitor: every launch must match the oldest outstanding vector.
    logic mon_prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            mon_prev_start = 1'b0;
        end else begin
            check("ready_vs_occupancy", s_ready, (occupancy != DEPTH));
            if (eng_start) begin
                n_launch++;
                check("start_spacing", mon_prev_start, 0);
                if (exp_q.size() == 0) check("launch_pending", (exp_q.size() != 0), 1);
                else check("eng_vector", eng_vector, exp_q.pop_front());
                last_vec = eng_vector;
            end
            mon_prev_start = eng_start;
        end
    end

    task automatic do_push(input logic [W-1:0] v, output bit acc);
        @(negedge clk);
        s_valid  = 1'b1;
        s_vector = v;
        acc      = s_ready;
        if (acc) begin
            if (SKIP_EN && (v == '1)) exp_dropped++;
            else exp_q.push_back(v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            seen    = eng_start;
        end
        check(name, seen, 1);
    endtask

    task automatic drain();
        int quiet = 0;
        busy_mode = BUSY_MODEL;
        for (int i = 0; i < 200 && quiet < 8; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if ((occupancy == 0) && !eng_start) quiet++;
            else quiet = 0;
        end
        check("drain_occupancy", occupancy, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit           acc;
        int           n0;
        int           nacc;
        logic [W-1:0] rv;

        rst      = 1'b1;
        s_valid  = 1'b0;
        s_vector = '0;
        repeat (3) @(negedge clk);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_vector", eng_vector, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_dropped", dropped_cnt, 0);
        check("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        idle(4);

        // Single vector latency: accepted in N, start in N+2.
        do_push(32'hFFFF_FFFE, acc);
        check("lat_accept", acc, 1);
        idle(1);
        check("lat_occ_n1", occupancy, 1);
        check("lat_start_n1", eng_start, 0);
        idle(1);
        check("lat_start_n2", eng_start, 1);
        check("lat_vector_n2", eng_vector, 32'hFFFF_FFFE);
        check("lat_occ_n2", occupancy, 0);
        idle(8);

        // Back-to-back pushes against a busy engine, then full with simultaneous pop.
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            rv    = $urandom();
            rv[0] = 1'b0;
            do_push(rv, acc);
            nacc += int'(acc);
        end
        check("b2b_accepted", nacc, 5);
        idle(1);
        check("b2b_full_occ", occupancy, 4);
        check("b2b_full_ready", s_ready, 0);
        idle(1);
        check("full_hold_ready", s_ready, 0);
        rv    = $urandom();
        rv[0] = 1'b0;
        do_push(rv, acc);
        check("full_pop_ready", acc, 1);
        check("full_pop_occ", occupancy, 3);
        check("full_pop_start", eng_start, 1);
        idle(1);
        check("full_refill_occ", occupancy, 4);
        drain();

        // Busy held high: FIFO fills and stalls. Then busy drops with no lag: no double launch.
        busy_mode = BUSY_HIGH;
        idle(2);
        n0   = n_launch;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            rv    = $urandom();
            rv[1] = 1'b0;
            do_push(rv, acc);
            nacc += int'(acc);
        end
        idle(4);
        check("busy_hold_accepted", nacc, 4);
        check("busy_hold_occ", occupancy, 4);
        check("busy_hold_ready", s_ready, 0);
        check("busy_hold_no_launch", n_launch - n0, 0);
        busy_mode = BUSY_LOW;
        wait_start("guard_first_launch");
        idle(1);
        check("guard_no_double", eng_start, 0);
        check("guard_occ", occupancy, 3);
        idle(1);
        check("guard_second_launch", eng_start, 1);
        drain();

        // Reset mid-stream with three entries queued and a start pulse in flight.
        busy_mode = BUSY_HIGH;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            rv    = $urandom();
            rv[2] = 1'b0;
            do_push(rv, acc);
        end
        idle(1);
        check("rst_mid_occ_full", occupancy, 4);
        busy_mode = BUSY_LOW;
        wait_start("rst_mid_launch");
        check("rst_mid_occ", occupancy, 3);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_dropped = 0;
        @(negedge clk);
        check("rst_mid_start", eng_start, 0);
        check("rst_mid_occ0", occupancy, 0);
        check("rst_mid_ready", s_ready, 0);
        check("rst_mid_dropped", dropped_cnt, 0);
        rst       = 1'b0;
        busy_mode = BUSY_MODEL;
        n0        = n_launch;
        idle(1);
        check("rst_mid_ready_after", s_ready, 1);
        idle(6);
        check("rst_mid_no_launch", n_launch - n0, 0);
        check("rst_mid_occ_after", occupancy, 0);

        // All-ones followed by all-zeros.
        idle(4);
        n0 = n_launch;
        do_push(32'hFFFF_FFFF, acc);
        do_push(32'h0000_0000, acc);
        idle(12);
        check("ones_launch_count", n_launch - n0, SKIP_EN ? 1 : 2);
        check("ones_last_vector", last_vec, 0);
        check("ones_dropped", dropped_cnt, exp_dropped);

        // Random traffic with the engine alternately modelled and never busy.
        for (int blk = 0; blk < 8; blk++) begin
            busy_mode = ($urandom_range(0, 2) == 0) ? BUSY_LOW : BUSY_MODEL;
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    case ($urandom_range(0, 7))
                        0:       rv = '1;
                        1:       rv = '0;
                        default: rv = $urandom();
                    endcase
                    do_push(rv, acc);
                end else begin
                    idle(1);
                end
            end
        end
        drain();
        check("final_dropped", dropped_cnt, exp_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
